// File: rtl/seg7_serial_driver.sv
// Serial driver for a two-digit multiplexed 7-segment display.
// Shifts each digit's font pattern into the external register, latches it, then dwells with its enable on.
module seg7_serial_driver #(
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       dp_a,
    input  logic       dp_b,
    input  logic       load,
    output logic       seg_si,
    output logic       seg_sck,
    output logic       seg_rck,
    output logic       seg_a_en,
    output logic       seg_b_en,
    output logic       frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;

    logic [1:0]       state;
    logic             digit_b;
    logic [9:0]       shadow;
    logic [7:0]       pattern;
    logic [2:0]       bit_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [REF_W-1:0] dwell_cnt;

    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic [6:0] seg_font;
    logic [7:0] next_pattern;

    // Font lookup for the digit about to be shifted; shadow is {dp_a, dp_b, value}.
    always_comb begin
        cur_nibble = digit_b ? shadow[3:0] : shadow[7:4];
        cur_dp     = digit_b ? shadow[8] : shadow[9];
        seg_font   = 7'h00;
        case (cur_nibble)
            4'h0: seg_font = 7'h3F;
            4'h1: seg_font = 7'h06;
            4'h2: seg_font = 7'h5B;
            4'h3: seg_font = 7'h4F;
            4'h4: seg_font = 7'h66;
            4'h5: seg_font = 7'h6D;
            4'h6: seg_font = 7'h7D;
            4'h7: seg_font = 7'h07;
            4'h8: seg_font = 7'h7F;
            4'h9: seg_font = 7'h6F;
            4'hA: seg_font = 7'h77;
            4'hB: seg_font = 7'h7C;
            4'hC: seg_font = 7'h39;
            4'hD: seg_font = 7'h5E;
            4'hE: seg_font = 7'h79;
            4'hF: seg_font = 7'h71;
            default: seg_font = 7'h00;
        endcase
        next_pattern = {cur_dp, seg_font};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_BLANK;
            digit_b    <= 1'b0;
            shadow     <= 10'd0;
            pattern    <= 8'd0;
            bit_idx    <= 3'd7;
            div_cnt    <= '0;
            dwell_cnt  <= '0;
            seg_si     <= 1'b0;
            seg_sck    <= 1'b0;
            seg_rck    <= 1'b0;
            seg_a_en   <= 1'b0;
            seg_b_en   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow <= {dp_a, dp_b, value};
            end
            frame_done <= 1'b0;

            case (state)
                ST_BLANK: begin
                    // seg_si is driven straight from the font so the first low phase already carries the MSB.
                    pattern  <= next_pattern;
                    bit_idx  <= 3'd7;
                    div_cnt  <= '0;
                    seg_si   <= next_pattern[7];
                    seg_sck  <= 1'b0;
                    seg_a_en <= 1'b0;
                    seg_b_en <= 1'b0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!seg_sck) begin
                            seg_sck <= 1'b1;
                        end else begin
                            seg_sck <= 1'b0;
                            if (bit_idx == 3'd0) begin
                                seg_si  <= 1'b0;
                                seg_rck <= 1'b1;
                                state   <= ST_LATCH;
                            end else begin
                                bit_idx <= bit_idx - 3'd1;
                                seg_si  <= pattern[bit_idx - 3'd1];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        dwell_cnt <= '0;
                        seg_rck   <= 1'b0;
                        seg_a_en  <= ~digit_b;
                        seg_b_en  <= digit_b;
                        state     <= ST_DWELL;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    if (dwell_cnt == REF_LAST) begin
                        seg_a_en   <= 1'b0;
                        seg_b_en   <= 1'b0;
                        frame_done <= digit_b;
                        digit_b    <= ~digit_b;
                        state      <= ST_BLANK;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
